// File: rtl/mix_columns_iter_pkg.sv
// Shared AES definitions: FSM state encoding, GF(2^8) reduction constant and xtime.
package mix_columns_iter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [7:0] RED_POLY = 8'h1b;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? RED_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/mix_column_word.sv
// Forward MixColumns of one 32-bit column; row 0 sits in the most significant byte.
module mix_column_word
  import mix_columns_iter_pkg::*;
(
  input  logic [31:0] col,
  output logic [31:0] mixed
);

  logic [7:0] a0, a1, a2, a3;
  logic [7:0] d0, d1, d2, d3;
  logic [7:0] t0, t1, t2, t3;

  assign {a0, a1, a2, a3} = col;

  assign d0 = xtime(a0);
  assign d1 = xtime(a1);
  assign d2 = xtime(a2);
  assign d3 = xtime(a3);

  assign t0 = d0 ^ a0;
  assign t1 = d1 ^ a1;
  assign t2 = d2 ^ a2;
  assign t3 = d3 ^ a3;

  assign mixed[31:24] = d0 ^ t1 ^ a2 ^ a3;
  assign mixed[23:16] = a0 ^ d1 ^ t2 ^ a3;
  assign mixed[15:8]  = a0 ^ a1 ^ d2 ^ t3;
  assign mixed[7:0]   = t0 ^ a1 ^ a2 ^ d3;

endmodule

// File: rtl/mix_columns_iter.sv
// Iterative AES MixColumns: transforms COLS_PER_CYCLE columns per cycle in place.
//   state | meaning
//   IDLE  | waiting for in_valid, in_ready high
//   BUSY  | transforming column groups in ascending order
//   DONE  | result held on out_state until out_ready
module mix_columns_iter
  import mix_columns_iter_pkg::*;
#(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic         busy
);

  localparam logic [1:0] CTR_STEP = 2'(COLS_PER_CYCLE);

  state_t           state, state_next;
  logic [1:0]       ctr;
  logic [0:3][31:0] work;
  logic [0:3][31:0] next_work;
  logic             last_group;

  logic [1:0]  col_idx [COLS_PER_CYCLE];
  logic [31:0] mixed   [COLS_PER_CYCLE];

  // 3-bit sum so that a full group of four is seen as reaching column 4.
  assign last_group = (({1'b0, ctr} + 3'(COLS_PER_CYCLE)) == 3'd4);

  for (genvar k = 0; k < COLS_PER_CYCLE; k++) begin : g_col
    assign col_idx[k] = ctr + 2'(k);
    mix_column_word u_word (
      .col   (work[col_idx[k]]),
      .mixed (mixed[k])
    );
  end

  always_comb begin
    next_work = work;
    for (int k = 0; k < COLS_PER_CYCLE; k++) begin
      next_work[col_idx[k]] = mixed[k];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid)   state_next = BUSY;
      BUSY:    if (last_group) state_next = DONE;
      DONE:    if (out_ready)  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctr  <= 2'd0;
      work <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            work <= in_state;
            ctr  <= 2'd0;
          end
        end
        BUSY: begin
          work <= next_work;
          ctr  <= ctr + CTR_STEP;
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state == BUSY);
  assign out_state = work;

endmodule

// File: doc/mix_columns_iter.md
MIX_COLUMNS_ITER -- requirements
Module: mix_columns_iter

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 The block SHALL have one parameter: COLS_PER_CYCLE, default 1, number of state columns transformed per cycle (legal values 1, 2, 4).
REQ-003 Port clk, input, 1, rising-edge clock.
REQ-004 Port rst_n, input, 1, asynchronous active-low reset.
REQ-005 Port in_valid, input, 1, in_state is valid.
REQ-006 Port in_ready, output, 1, block can accept a state.
REQ-007 Port in_state, input, 128, AES state; byte s[r][c] = bits [127-32c-8r -: 8].
REQ-008 Port out_valid, output, 1, out_state holds a completed result.
REQ-009 Port out_ready, input, 1, consumer accepts out_state.
REQ-010 Port out_state, output, 128, forward MixColumns of the accepted state, same byte layout as in_state.
REQ-011 Port busy, output, 1, high in the BUSY state.

Function
REQ-012 The block SHALL implement the forward AES MixColumns transform (FIPS-197 5.1.3), the inverse of the team's InvMixColumns, per column: b0=2a0^3a1^a2^a3, b1=a0^2a1^3a2^a3, b2=a0^a1^2a2^3a3, b3=3a0^a1^a2^2a3.
REQ-013 GF(2^8) doubling SHALL be {a[6:0],0} XOR (a[7] ? 8'h1b : 0); tripling SHALL be double XOR a; all datapath values SHALL be exactly 8 bits wide.
REQ-014 The FSM SHALL have three states: IDLE, BUSY, DONE.
REQ-015 in_ready SHALL equal (state==IDLE); out_valid SHALL equal (state==DONE).
REQ-016 IDLE with in_valid high: on that edge, latch in_state into the work register, clear the column counter, and go to BUSY.
REQ-017 BUSY: each cycle, transform COLS_PER_CYCLE columns, starting at column 0 and in ascending order, and write them in place; increment the counter by COLS_PER_CYCLE.
REQ-018 The counter SHALL be 2 bits wide and wrap to 0; after the last group (counter+COLS_PER_CYCLE reaches 4), go to DONE.
REQ-019 Latency: out_valid SHALL rise exactly 4/COLS_PER_CYCLE cycles after the accepting edge (4 cycles at default).
REQ-020 DONE: out_state SHALL hold stable until out_ready is high; on that edge, go to IDLE.
REQ-021 The block SHALL accept no new input in BUSY or DONE; in_valid and in_state changes there SHALL have no effect.
REQ-022 Simultaneous out_ready and in_valid in DONE: the output SHALL be retired, and the new state SHALL NOT be accepted until the following IDLE cycle.
REQ-023 out_state SHALL be driven directly from the work register; contents are don't-care outside DONE but SHALL NOT contain X after reset.

Reset
REQ-024 Asserting rst_n low SHALL immediately set state=IDLE, counter=0 and work register=128'h0, so in_ready=1, out_valid=0 and busy=0.
REQ-025 Reset asserted during BUSY or DONE SHALL abort the operation and discard the partial result; no out_valid SHALL follow.

Structure
REQ-026 The shared AES package SHALL hold the FSM state typedef, the reduction constant 8'h1b, and the xtime function.
REQ-027 One combinational sub-module, mix_column_word (32-bit column in, 32-bit column out), SHALL be instantiated COLS_PER_CYCLE times.
REQ-028 All storage SHALL reside in mix_columns_iter; implementation target is 120-400 lines of RTL.

Verification
REQ-029 Apply in_state d4bf5d30e0b452aeb84111f11e2798e5 -> out_state 046681e5e0cb199a48f8d37a2806264c, with out_valid exactly 4 cycles after acceptance.
REQ-030 Apply columns db135345, f20a225c, 01010101, c6c6c6c6 -> out_state 8e4da1bc 9fdc589d 01010101 c6c6c6c6.
REQ-031 Apply columns d4d4d4d5, 2d26314c and zeros -> out_state d5d5d7d6 4d7ebdf8 00000000 00000000; then feed the result through InvMixColumns -> original input.
REQ-032 Hold out_ready low for 10 cycles in DONE while toggling in_valid/in_state -> out_state stable, in_ready stays 0, nothing accepted.
REQ-033 Pulse rst_n low in the 2nd BUSY cycle -> in_ready=1 and out_valid=0 immediately; the next input produces a correct result.
REQ-034 Repeat REQ-029 with COLS_PER_CYCLE=2 and 4 -> identical out_state, with latency 2 and 1 cycles respectively.
